memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of Execute in the 16-bit core. Consumes Execute's registered result, store data, control and destination index.
- Performs LOAD/STORE through a req/ack data-memory port, stalling upstream while an access is outstanding.
- Passes all other ops (ALU, LOADI, MOV, jumps, NOP) to Writeback through a one-cycle pipeline register.

Parameters:
- DATA_W, 16, data/address width
- IDX_W, 5, register index width
- CTRL_W, 5, control word width; bits [3:0] are the opcode
- TIMEOUT_CYCLES, 15, ack watchdog limit; used only with MEM_ACK_TIMEOUT_EN

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  Execute output holds a valid op this cycle
- control_in  in  CTRL_W  control word from Execute
- dest_index_in  in  IDX_W  destination register index
- result_in  in  DATA_W  ALU result; memory address for LOAD/STORE
- store_data_in  in  DATA_W  register data to store
- reg_write_en_in  in  1  Execute's destination write enable
- stall  out  1  upstream must hold all inputs stable while high
- mem_req  out  1  data memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse
- valid_out  out  1  Writeback output holds a valid op this cycle
- control_out  out  CTRL_W  forwarded control word
- dest_index_out  out  IDX_W  forwarded destination index
- wb_data_out  out  DATA_W  mem_rdata for LOAD, otherwise result_in
- reg_write_en_out  out  1  Writeback enable
- mem_error  out  1  sticky watchdog error

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - All outputs go to 0: stall, mem_req, mem_we, mem_addr, mem_wdata, valid_out, control_out, dest_index_out, wb_data_out, reg_write_en_out, mem_error.
  - Reset asserted during ACCESS abandons the access. mem_req is 0 from the next cycle and no valid_out is produced for it.
- Memory op decode: opcode = control_in[3:0]. LOAD=4'b1100 and STORE=4'b1110 are memory ops. Every other opcode, including LOADI=1101, is pass-through. control_in[4] is ignored for decode.
- FSM states: IDLE and ACCESS. stall = (state==ACCESS), as a combinational output of state.
- IDLE, valid_in=0: valid_out<=0 and reg_write_en_out<=0; other outputs hold.
- IDLE, valid_in=1, pass-through op:
  - Next edge: valid_out<=1; control_out, dest_index_out and reg_write_en_out take the inputs; wb_data_out<=result_in.
  - Latency is 1 cycle. Back-to-back pass-through ops run at 1 per cycle.
- IDLE, valid_in=1, memory op:
  - Next edge: latch control, dest index and write enable; mem_addr<=result_in; mem_wdata<=store_data_in; mem_we<=(STORE); mem_req<=1; valid_out<=0; state<=ACCESS.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. Inputs are ignored.
  - On a cycle with mem_ack=1, the next edge sets: mem_req<=0; state<=IDLE; valid_out<=1; latched control and index to the outputs.
    - LOAD: wb_data_out<=mem_rdata; reg_write_en_out<=latched write enable.
    - STORE: wb_data_out<=mem_addr; reg_write_en_out<=0.
  - The upstream op held during the ack cycle is accepted on the following IDLE cycle.
  - Zero-wait memory (ack in the first ACCESS cycle) gives 2-cycle latency. Each ack wait cycle adds 1.
- mem_ack while in IDLE is ignored.
- STORE never writes the register file, regardless of reg_write_en_in.
- No arithmetic is performed. Addresses are used unmodified; no wrap logic is needed.

Optional Feature:
- MEM_ACK_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack, the next edge sets: mem_req<=0; state<=IDLE; valid_out<=1 with reg_write_en_out<=0; mem_error<=1.
  - mem_error stays set until reset.
  - An ack arriving on the final counted cycle wins; that is a normal completion.
- MEM_ACK_TIMEOUT_EN not defined:
  - ACCESS waits indefinitely for ack.
  - mem_error is tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants NOP..MOV (4-bit), common with Execute and Decode.
  - DATA_W, IDX_W and CTRL_W defaults.
  - FSM state enum for IDLE/ACCESS.
- Optional sub-module mem_ack_watchdog: counter plus timeout pulse, instantiated only under MEM_ACK_TIMEOUT_EN. All else is in one module.

Test Plan:
- ADD pass-through: ctrl=0x02, result=15, dest=2, wen=1 -> next cycle valid_out=1, wb_data_out=15, reg_write_en_out=1, stall=0, mem_req never asserts.
- LOAD, zero-wait: ctrl=0x0C, result=0x0040, memory acks in the first ACCESS cycle with rdata=0xBEEF -> mem_req=1/mem_we=0/mem_addr=0x0040 for 1 cycle, stall=1 for 1 cycle, valid_out=1 with wb_data_out=0xBEEF two cycles after input.
- STORE, 3-cycle ack wait: ctrl=0x0E, result=0x0010, store_data=0x1234, wen=1 -> mem_we=1, mem_wdata=0x1234 stable for 4 ACCESS cycles, stall high 4 cycles, then valid_out=1 with reg_write_en_out=0.
- Back-to-back LOAD then ADDI (held during stall) -> ADDI result appears exactly 1 cycle after LOAD's valid_out; no op is lost or duplicated.
- Reset asserted in the 2nd ACCESS cycle of a LOAD -> next cycle all outputs 0 and state IDLE; a late mem_ack is ignored; no valid_out.
- MEM_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> after 15 ACCESS cycles mem_req=0, valid_out=1 with reg_write_en_out=0, mem_error=1 held until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode map, default datapath widths and the memory-stage FSM
// state type. Shared with the Decode and Execute stages.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_IDX_W  = 5;
   localparam int CPU_CTRL_W = 5;

   // 4-bit opcodes carried in control[3:0]
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_ADDI  = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_SHL   = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JZ    = 4'h9;
   localparam logic [3:0] OP_LOAD  = 4'hC;
   localparam logic [3:0] OP_LOADI = 4'hD;
   localparam logic [3:0] OP_STORE = 4'hE;
   localparam logic [3:0] OP_MOV   = 4'hF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   // Only LOAD and STORE touch the data memory; LOADI is an immediate move.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_ack_watchdog.sv
// mem_ack_watchdog: counts ACCESS cycles without an ack and flags the
// cycle on which the access must be abandoned. Only built when
// MEM_ACK_TIMEOUT_EN is defined.
module mem_ack_watchdog #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic start,    // entering ACCESS on the next edge
   input  logic active,   // currently in ACCESS
   input  logic ack,
   output logic timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // An ack on the final counted cycle wins over the timeout.
   assign timeout = active && !ack && (count_q == LAST);

   // Next count: clear on entry, advance on every un-acked ACCESS cycle.
   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = '0;
      end else if (active && !ack) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: pipeline stage after Execute. LOAD/STORE go through
// the req/ack data-memory port while upstream is stalled; every other op
// reaches Writeback through a one-cycle register.
// Optional ack watchdog: define MEM_ACK_TIMEOUT_EN.
module memory_access_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W         = CPU_DATA_W,
   parameter int IDX_W          = CPU_IDX_W,
   parameter int CTRL_W         = CPU_CTRL_W,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] control_in,
   input  logic [IDX_W-1:0]  dest_index_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic              reg_write_en_in,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              valid_out,
   output logic [CTRL_W-1:0] control_out,
   output logic [IDX_W-1:0]  dest_index_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              reg_write_en_out,
   output logic              mem_error
);

   // A zero-length watchdog window could never let an ack land.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   mem_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              valid_out_q, valid_out_d;
   logic [CTRL_W-1:0] control_out_q, control_out_d;
   logic [IDX_W-1:0]  dest_index_out_q, dest_index_out_d;
   logic [DATA_W-1:0] wb_data_out_q, wb_data_out_d;
   logic              reg_write_en_out_q, reg_write_en_out_d;
   // Memory op held while the access is outstanding
   logic [CTRL_W-1:0] ctrl_lat_q, ctrl_lat_d;
   logic [IDX_W-1:0]  dest_lat_q, dest_lat_d;
   logic              wen_lat_q, wen_lat_d;

   logic [3:0] op_in;
   logic       timeout;

   assign op_in = control_in[3:0];

`ifdef MEM_ACK_TIMEOUT_EN
   logic mem_error_q, mem_error_d;
   logic wd_start;

   assign wd_start = (state_q == ST_IDLE) && valid_in && is_mem_op(op_in);

   mem_ack_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .start  (wd_start),
      .active (state_q == ST_ACCESS),
      .ack    (mem_ack),
      .timeout(timeout)
   );

   // Sticky error: set by any timeout, cleared only by reset.
   always_comb begin
      mem_error_d = mem_error_q | timeout;
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_error_q <= 1'b0;
      end else begin
         mem_error_q <= mem_error_d;
      end
   end

   assign mem_error = mem_error_q;
`else
   assign timeout   = 1'b0;
   assign mem_error = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE/ACCESS machine.
   always_comb begin
      // NOTE: every _d starts from its _q, so no path can leave one unassigned and infer a latch.
      state_d            = state_q;
      mem_req_d          = mem_req_q;
      mem_we_d           = mem_we_q;
      mem_addr_d         = mem_addr_q;
      mem_wdata_d        = mem_wdata_q;
      valid_out_d        = valid_out_q;
      control_out_d      = control_out_q;
      dest_index_out_d   = dest_index_out_q;
      wb_data_out_d      = wb_data_out_q;
      reg_write_en_out_d = reg_write_en_out_q;
      ctrl_lat_d         = ctrl_lat_q;
      dest_lat_d         = dest_lat_q;
      wen_lat_d          = wen_lat_q;

      case (state_q)
         ST_IDLE: begin
            valid_out_d        = 1'b0;
            reg_write_en_out_d = 1'b0;
            if (valid_in) begin
               if (is_mem_op(op_in)) begin
                  ctrl_lat_d  = control_in;
                  dest_lat_d  = dest_index_in;
                  wen_lat_d   = reg_write_en_in;
                  mem_addr_d  = result_in;
                  mem_wdata_d = store_data_in;
                  mem_we_d    = (op_in == OP_STORE);
                  mem_req_d   = 1'b1;
                  state_d     = ST_ACCESS;
               end else begin
                  valid_out_d        = 1'b1;
                  control_out_d      = control_in;
                  dest_index_out_d   = dest_index_in;
                  reg_write_en_out_d = reg_write_en_in;
                  wb_data_out_d      = result_in;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               mem_req_d        = 1'b0;
               state_d          = ST_IDLE;
               valid_out_d      = 1'b1;
               control_out_d    = ctrl_lat_q;
               dest_index_out_d = dest_lat_q;
               if (ctrl_lat_q[3:0] == OP_LOAD) begin
                  wb_data_out_d      = mem_rdata;
                  reg_write_en_out_d = wen_lat_q;
               end else begin
                  // A STORE reports its address and never writes the register file.
                  wb_data_out_d      = mem_addr_q;
                  reg_write_en_out_d = 1'b0;
               end
            end else if (timeout) begin
               mem_req_d          = 1'b0;
               state_d            = ST_IDLE;
               valid_out_d        = 1'b1;
               control_out_d      = ctrl_lat_q;
               dest_index_out_d   = dest_lat_q;
               reg_write_en_out_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
      if (reset) begin
         state_q            <= ST_IDLE;
         mem_req_q          <= 1'b0;
         mem_we_q           <= 1'b0;
         mem_addr_q         <= '0;
         mem_wdata_q        <= '0;
         valid_out_q        <= 1'b0;
         control_out_q      <= '0;
         dest_index_out_q   <= '0;
         wb_data_out_q      <= '0;
         reg_write_en_out_q <= 1'b0;
         ctrl_lat_q         <= '0;
         dest_lat_q         <= '0;
         wen_lat_q          <= 1'b0;
      end else begin
         state_q            <= state_d;
         mem_req_q          <= mem_req_d;
         mem_we_q           <= mem_we_d;
         mem_addr_q         <= mem_addr_d;
         mem_wdata_q        <= mem_wdata_d;
         valid_out_q        <= valid_out_d;
         control_out_q      <= control_out_d;
         dest_index_out_q   <= dest_index_out_d;
         wb_data_out_q      <= wb_data_out_d;
         reg_write_en_out_q <= reg_write_en_out_d;
         ctrl_lat_q         <= ctrl_lat_d;
         dest_lat_q         <= dest_lat_d;
         wen_lat_q          <= wen_lat_d;
      end
   end

   assign stall            = (state_q == ST_ACCESS);
   assign mem_req          = mem_req_q;
   assign mem_we           = mem_we_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign valid_out        = valid_out_q;
   assign control_out      = control_out_q;
   assign dest_index_out   = dest_index_out_q;
   assign wb_data_out      = wb_data_out_q;
   assign reg_write_en_out = reg_write_en_out_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: table of ops driven back to back, a memory
// responder with per-op ack delay, and a scoreboard checking every
// valid_out against expected data and cycle. Hand-written sequences cover
// ack in IDLE, reset mid-access and (with MEM_ACK_TIMEOUT_EN) the watchdog.
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [4:0]  control_in;
   logic [4:0]  dest_index_in;
   logic [15:0] result_in;
   logic [15:0] store_data_in;
   logic        reg_write_en_in;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        valid_out;
   logic [4:0]  control_out;
   logic [4:0]  dest_index_out;
   logic [15:0] wb_data_out;
   logic        reg_write_en_out;
   logic        mem_error;

   always #5 clk = ~clk;

   memory_access_stage dut (
      .clk             (clk),
      .reset           (reset),
      .valid_in        (valid_in),
      .control_in      (control_in),
      .dest_index_in   (dest_index_in),
      .result_in       (result_in),
      .store_data_in   (store_data_in),
      .reg_write_en_in (reg_write_en_in),
      .stall           (stall),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_ack         (mem_ack),
      .valid_out       (valid_out),
      .control_out     (control_out),
      .dest_index_out  (dest_index_out),
      .wb_data_out     (wb_data_out),
      .reg_write_en_out(reg_write_en_out),
      .mem_error       (mem_error)
   );

   typedef struct {
      string       name;
      logic [4:0]  ctrl;
      logic [4:0]  dest;
      logic [15:0] result;
      logic [15:0] sdata;
      logic        wen;
      logic        is_mem;
      int          delay;    // ack wait cycles after the first ACCESS cycle
      logic [15:0] rdata;
      logic [15:0] exp_wb;
      logic        exp_wen;
   } vec_t;

   typedef struct {
      string       name;
      logic [4:0]  ctrl;
      logic [4:0]  dest;
      logic [15:0] wb;
      logic        chk_wb;
      logic        wen;
      int          cyc;
   } exp_t;

   typedef struct {
      string       name;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          delay;
   } mreq_t;

   exp_t  sq[$];
   mreq_t mq[$];
   vec_t  vecs[10];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int k       = 0;

   logic        auto_mem = 1'b1;
   logic        r_ack    = 1'b0;
   logic [15:0] r_rdata  = '0;
   logic        man_ack  = 1'b0;
   logic [15:0] man_rdata = '0;

   assign mem_ack   = auto_mem ? r_ack : man_ack;
   assign mem_rdata = auto_mem ? r_rdata : man_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [4:0] ctrl, input logic [4:0] dest,
                               input logic [15:0] result, input logic [15:0] sdata, input logic wen,
                               input logic is_mem, input int delay, input logic [15:0] rdata,
                               input logic [15:0] exp_wb, input logic exp_wen);
      vec_t v;
      v.name = name; v.ctrl = ctrl; v.dest = dest; v.result = result; v.sdata = sdata;
      v.wen = wen; v.is_mem = is_mem; v.delay = delay; v.rdata = rdata;
      v.exp_wb = exp_wb; v.exp_wen = exp_wen;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: acks each request after its table delay and checks the port is stable.
   always @(negedge clk) begin
      r_ack <= 1'b0;
      if (auto_mem && !reset && mem_req === 1'b1) begin
         if (mq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_req_unexpected: got mem_req=1, expected 0 (cycle %0d)", cyc);
         end else begin
            check($sformatf("%s.mem_we", mq[0].name), mem_we, mq[0].we);
            check($sformatf("%s.mem_addr", mq[0].name), mem_addr, mq[0].addr);
            if (mq[0].we) check($sformatf("%s.mem_wdata", mq[0].name), mem_wdata, mq[0].wdata);
            check($sformatf("%s.stall", mq[0].name), stall, 1'b1);
            if (k == mq[0].delay) begin
               r_ack   <= 1'b1;
               r_rdata <= mq[0].rdata;
               void'(mq.pop_front());
               k <= 0;
            end else begin
               k <= k + 1;
            end
         end
      end
   end

   // Scoreboard: every valid_out must match the oldest outstanding op, on its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && valid_out === 1'b1) begin
         if (sq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_out_unexpected: got valid_out=1, expected 0 (cycle %0d)", cyc);
         end else begin
            e = sq.pop_front();
            check($sformatf("%s.control_out", e.name), control_out, e.ctrl);
            check($sformatf("%s.dest_index_out", e.name), dest_index_out, e.dest);
            if (e.chk_wb) check($sformatf("%s.wb_data_out", e.name), wb_data_out, e.wb);
            check($sformatf("%s.reg_write_en_out", e.name), reg_write_en_out, e.wen);
            check($sformatf("%s.cycle", e.name), cyc, e.cyc);
         end
      end
   end

   // Present one op at a negedge, wait out any stall, record expectations at acceptance.
   task automatic send(input vec_t v);
      int    guard;
      exp_t  e;
      mreq_t m;
      valid_in        = 1'b1;
      control_in      = v.ctrl;
      dest_index_in   = v.dest;
      result_in       = v.result;
      store_data_in   = v.sdata;
      reg_write_en_in = v.wen;
      guard = 0;
      while (stall !== 1'b0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s.accept: got stall=%0b after 40 cycles, expected 0", v.name, stall);
      end
      e.name = v.name; e.ctrl = v.ctrl; e.dest = v.dest; e.wb = v.exp_wb;
      e.chk_wb = 1'b1; e.wen = v.exp_wen;
      e.cyc = cyc + 1 + (v.is_mem ? v.delay + 1 : 0);
      sq.push_back(e);
      if (v.is_mem) begin
         m.name = v.name; m.we = (v.ctrl[3:0] == 4'hE); m.addr = v.result;
         m.wdata = v.sdata; m.rdata = v.rdata; m.delay = v.delay;
         mq.push_back(m);
      end
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((sq.size() != 0 || mq.size() != 0) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({name, ".pending"}, sq.size() + mq.size(), 0);
   endtask

   initial begin
      int n;
      vecs[0] = mk("add",      5'h02, 5'd2,  16'h000F, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'h000F, 1'b1);
      vecs[1] = mk("load_zw",  5'h0C, 5'd3,  16'h0040, 16'h0000, 1'b1, 1'b1, 0, 16'hBEEF, 16'hBEEF, 1'b1);
      vecs[2] = mk("store_w3", 5'h0E, 5'd4,  16'h0010, 16'h1234, 1'b1, 1'b1, 3, 16'h0000, 16'h0010, 1'b0);
      vecs[3] = mk("load_w2",  5'h0C, 5'd7,  16'h0100, 16'h0000, 1'b1, 1'b1, 2, 16'hA5A5, 16'hA5A5, 1'b1);
      vecs[4] = mk("addi_b2b", 5'h03, 5'd8,  16'h0077, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'h0077, 1'b1);
      vecs[5] = mk("nop",      5'h00, 5'd0,  16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0);
      vecs[6] = mk("loadi",    5'h0D, 5'd9,  16'h5555, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'h5555, 1'b1);
      vecs[7] = mk("load_b4",  5'h1C, 5'd10, 16'h0200, 16'h0000, 1'b0, 1'b1, 1, 16'h0F0F, 16'h0F0F, 1'b0);
      vecs[8] = mk("store_b4", 5'h1E, 5'd11, 16'h8000, 16'hCAFE, 1'b0, 1'b1, 0, 16'h0000, 16'h8000, 1'b0);
      vecs[9] = mk("mov",      5'h1F, 5'd31, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 16'hFFFF, 1'b1);

      reset = 1'b1; valid_in = 1'b0; control_in = '0; dest_index_in = '0;
      result_in = '0; store_data_in = '0; reg_write_en_in = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.stall", stall, 1'b0);
      check("reset.mem_req", mem_req, 1'b0);
      check("reset.valid_out", valid_out, 1'b0);
      check("reset.wb_data_out", wb_data_out, 16'h0000);
      check("reset.mem_error", mem_error, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Table ops, back to back
      foreach (vecs[i]) send(vecs[i]);
      valid_in = 1'b0;
      drain("table");

      // Idle holds the last data but drops valid and write enable
      @(negedge clk);
      check("idle.valid_out", valid_out, 1'b0);
      check("idle.reg_write_en_out", reg_write_en_out, 1'b0);
      check("idle.wb_data_out_hold", wb_data_out, 16'hFFFF);
      check("idle.control_out_hold", control_out, 5'h1F);
      check("idle.dest_index_out_hold", dest_index_out, 5'd31);

      // mem_ack while IDLE is ignored
      auto_mem = 1'b0;
      man_ack = 1'b1; man_rdata = 16'hDEAD;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      check("idle_ack.valid_out", valid_out, 1'b0);
      check("idle_ack.stall", stall, 1'b0);
      check("idle_ack.mem_req", mem_req, 1'b0);
      check("idle_ack.wb_data_out", wb_data_out, 16'hFFFF);

      // Reset in the second ACCESS cycle of a LOAD abandons it
      valid_in = 1'b1; control_in = 5'h0C; dest_index_in = 5'd4;
      result_in = 16'h0040; store_data_in = 16'h0000; reg_write_en_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      check("rst_acc.mem_req_1", mem_req, 1'b1);
      check("rst_acc.stall_1", stall, 1'b1);
      check("rst_acc.mem_addr", mem_addr, 16'h0040);
      @(negedge clk);
      check("rst_acc.mem_req_2", mem_req, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_acc.stall", stall, 1'b0);
      check("rst_acc.mem_req", mem_req, 1'b0);
      check("rst_acc.mem_we", mem_we, 1'b0);
      check("rst_acc.mem_addr0", mem_addr, 16'h0000);
      check("rst_acc.mem_wdata", mem_wdata, 16'h0000);
      check("rst_acc.valid_out", valid_out, 1'b0);
      check("rst_acc.control_out", control_out, 5'h00);
      check("rst_acc.dest_index_out", dest_index_out, 5'd0);
      check("rst_acc.wb_data_out", wb_data_out, 16'h0000);
      check("rst_acc.reg_write_en_out", reg_write_en_out, 1'b0);
      check("rst_acc.mem_error", mem_error, 1'b0);
      man_ack = 1'b1; man_rdata = 16'hBEEF;
      @(negedge clk);
      man_ack = 1'b0;
      check("late_ack.valid_out", valid_out, 1'b0);
      check("late_ack.mem_req", mem_req, 1'b0);
      check("late_ack.stall", stall, 1'b0);
      @(negedge clk);
      check("late_ack.valid_out_2", valid_out, 1'b0);
      check("late_ack.wb_data_out", wb_data_out, 16'h0000);

      // Recovery after reset
      auto_mem = 1'b1;
      send(vecs[3]);
      send(vecs[0]);
      valid_in = 1'b0;
      drain("recover");

`ifdef MEM_ACK_TIMEOUT_EN
      // Watchdog: LOAD that is never acked
      begin
         exp_t e;
         auto_mem = 1'b0;
         valid_in = 1'b1; control_in = 5'h0C; dest_index_in = 5'd5;
         result_in = 16'h0300; store_data_in = 16'h0000; reg_write_en_in = 1'b1;
         e.name = "timeout"; e.ctrl = 5'h0C; e.dest = 5'd5; e.wb = 16'h0000;
         e.chk_wb = 1'b0; e.wen = 1'b0; e.cyc = cyc + 1 + 15;
         sq.push_back(e);
         @(negedge clk);
         valid_in = 1'b0;
         n = 0;
         while (mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
         end
         check("timeout.req_cycles", n, 15);
         check("timeout.mem_error", mem_error, 1'b1);
         check("timeout.valid_out", valid_out, 1'b1);
         check("timeout.stall", stall, 1'b0);
         repeat (3) @(negedge clk);
         check("timeout.mem_error_sticky", mem_error, 1'b1);
         check("timeout.valid_out_after", valid_out, 1'b0);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("timeout.mem_error_reset", mem_error, 1'b0);
         auto_mem = 1'b1;
      end
`else
      n = 0;
      check("no_watchdog.mem_error", mem_error, 1'b0);
`endif

      drain("final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected finish before 200000");
      $fatal(1, "simulation time limit");
   end

endmodule
